// File: rtl/branch_predictor.sv
// branch_predictor
//   Direct-mapped branch history table of saturating counters combined with a
//   tagged branch target buffer. Fetch gets a same-cycle taken/target guess for
//   pc_f; execute trains the table when a branch or jump resolves, using the
//   index that was captured at fetch time (idx_f travelling down as upd_idx_e).
//
//   Optional feature: define BPRED_GSHARE_EN to XOR a global history register
//   (non-speculative, conditional branches only) into the lookup index.
//   Tags always come straight from the PC, in both modes.

module branch_predictor #(
    parameter int WIDTH    = 32,
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2,
    parameter int TAG_BITS = 8,
    localparam int IDX_BITS = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic                rst,
    // fetch-side lookup
    input  logic [WIDTH-1:0]    pc_f,
    output logic                bp_f,
    output logic                hit_f,
    output logic [WIDTH-1:0]    pred_target_f,
    output logic [IDX_BITS-1:0] idx_f,
    // execute-side training
    input  logic                upd_valid_e,
    input  logic                upd_jump_e,
    input  logic                upd_taken_e,
    input  logic [WIDTH-1:0]    upd_pc_e,
    input  logic [WIDTH-1:0]    upd_target_e,
    input  logic [IDX_BITS-1:0] upd_idx_e
);

    // Counter encodings: strongest taken, weakly taken (allocation value),
    // weakly not-taken (reset value). With CTR_BITS=1 these are 1, 1, 0.
    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(2 ** (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(2 ** (CTR_BITS - 1) - 1);

    localparam int TAG_LO = IDX_BITS + 2;
    localparam int TAG_HI = IDX_BITS + 2 + TAG_BITS - 1;

    // Saturating increment: stays at all-ones.
    function automatic logic [CTR_BITS-1:0] sat_inc(input logic [CTR_BITS-1:0] c);
        if (c == CTR_MAX) begin
            return c;
        end else begin
            return c + CTR_BITS'(1);
        end
    endfunction

    // Saturating decrement: stays at zero.
    function automatic logic [CTR_BITS-1:0] sat_dec(input logic [CTR_BITS-1:0] c);
        if (c == {CTR_BITS{1'b0}}) begin
            return c;
        end else begin
            return c - CTR_BITS'(1);
        end
    endfunction

    // ------------------------------------------------------------------
    // Table storage. valid and ctr are reset; tag and target are only
    // meaningful behind valid and so carry no reset.
    // ------------------------------------------------------------------
    logic                valid_q  [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [WIDTH-1:0]    target_q [ENTRIES];

    // PC field extraction
    logic [IDX_BITS-1:0] pidx_f_s;
    logic [TAG_BITS-1:0] tag_f_s;
    logic [TAG_BITS-1:0] tag_e_s;

    assign pidx_f_s = pc_f[IDX_BITS+1:2];
    assign tag_f_s  = pc_f[TAG_HI:TAG_LO];
    assign tag_e_s  = upd_pc_e[TAG_HI:TAG_LO];

    // ------------------------------------------------------------------
    // Lookup index: plain PC index, or PC index hashed with global history.
    // ------------------------------------------------------------------
`ifdef BPRED_GSHARE_EN
    logic [IDX_BITS-1:0] ghr_q;
    logic [IDX_BITS-1:0] ghr_d;
    logic [IDX_BITS:0]   ghr_shift_s;

    // Widened shift keeps the IDX_BITS=1 case legal: the result is just the outcome.
    assign ghr_shift_s = {ghr_q, upd_taken_e};

    // Next history: only resolved conditional branches shift in their outcome.
    always_comb begin
        ghr_d = ghr_q;
        if (upd_valid_e && !upd_jump_e) begin
            ghr_d = ghr_shift_s[IDX_BITS-1:0];
        end else begin
            ghr_d = ghr_q;
        end
    end

    // History register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= {IDX_BITS{1'b0}};
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign idx_f = pidx_f_s ^ ghr_q;
`else
    assign idx_f = pidx_f_s;
`endif

    // ------------------------------------------------------------------
    // Combinational lookup. No bypass from a same-cycle update: the old
    // entry contents are returned and the new ones appear next cycle.
    // ------------------------------------------------------------------
    assign hit_f         = valid_q[idx_f] && (tag_q[idx_f] == tag_f_s);
    assign bp_f          = hit_f && ctr_q[idx_f][CTR_BITS-1];
    assign pred_target_f = target_q[idx_f];

    // ------------------------------------------------------------------
    // Training decision
    // ------------------------------------------------------------------
    logic                uhit_s;
    logic                meta_we_s;   // write valid/tag/target
    logic                ctr_we_s;    // write counter
    logic [CTR_BITS-1:0] upd_ctr_d;

    assign uhit_s = valid_q[upd_idx_e] && (tag_q[upd_idx_e] == tag_e_s);

    // Decide which fields of the trained entry change and the new counter value.
    always_comb begin
        meta_we_s = 1'b0;
        ctr_we_s  = 1'b0;
        upd_ctr_d = ctr_q[upd_idx_e];
        if (!upd_valid_e) begin
            meta_we_s = 1'b0;
            ctr_we_s  = 1'b0;
        end else if (upd_jump_e) begin
            // unconditional: install and pin strongly taken
            meta_we_s = 1'b1;
            ctr_we_s  = 1'b1;
            upd_ctr_d = CTR_MAX;
        end else if (uhit_s && upd_taken_e) begin
            // reinforce and refresh the target (indirect targets can move)
            meta_we_s = 1'b1;
            ctr_we_s  = 1'b1;
            upd_ctr_d = sat_inc(ctr_q[upd_idx_e]);
        end else if (uhit_s) begin
            // weaken; the stored target is kept
            meta_we_s = 1'b0;
            ctr_we_s  = 1'b1;
            upd_ctr_d = sat_dec(ctr_q[upd_idx_e]);
        end else if (upd_taken_e) begin
            // taken branch not in the table: allocate, replacing any alias
            meta_we_s = 1'b1;
            ctr_we_s  = 1'b1;
            upd_ctr_d = CTR_WT;
        end else begin
            // not-taken miss: nothing worth remembering
            meta_we_s = 1'b0;
            ctr_we_s  = 1'b0;
        end
    end

    // Valid bits and counters: asynchronous clear, trained on resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else begin
            if (meta_we_s) begin
                valid_q[upd_idx_e] <= 1'b1;
            end
            if (ctr_we_s) begin
                ctr_q[upd_idx_e] <= upd_ctr_d;
            end
        end
    end

    // Tag and target arrays: written alongside valid, never cleared.
    always_ff @(posedge clk) begin
        if (meta_we_s) begin
            tag_q[upd_idx_e]    <= tag_e_s;
            target_q[upd_idx_e] <= upd_target_e;
        end
    end

    // PC bits outside the index/tag fields carry no information here.
`ifdef BPRED_GSHARE_EN
    logic unused_s;
    assign unused_s = ^{pc_f, upd_pc_e, ghr_shift_s[IDX_BITS]};
`else
    logic unused_s;
    assign unused_s = ^{pc_f, upd_pc_e};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default parameters:
// 64 entries, 2-bit counters, 8-bit tags). For ENTRIES=64 the index is
// pc[7:2] and the tag is pc[15:8], so 0x100/0x200/0x300 all share index 0.
`timescale 1ns/1ps

module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] pc_f;
    logic        bp_f;
    logic        hit_f;
    logic [31:0] pred_target_f;
    logic [5:0]  idx_f;
    logic        upd_valid_e;
    logic        upd_jump_e;
    logic        upd_taken_e;
    logic [31:0] upd_pc_e;
    logic [31:0] upd_target_e;
    logic [5:0]  upd_idx_e;

    int errors;
    int checks;

    branch_predictor #(
        .WIDTH(32), .ENTRIES(64), .CTR_BITS(2), .TAG_BITS(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_f         (pc_f),
        .bp_f         (bp_f),
        .hit_f        (hit_f),
        .pred_target_f(pred_target_f),
        .idx_f        (idx_f),
        .upd_valid_e  (upd_valid_e),
        .upd_jump_e   (upd_jump_e),
        .upd_taken_e  (upd_taken_e),
        .upd_pc_e     (upd_pc_e),
        .upd_target_e (upd_target_e),
        .upd_idx_e    (upd_idx_e)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One training pulse across one rising edge; returns 1ns after the edge.
    task automatic do_upd(input logic [31:0] pc, input logic taken, input logic jump,
                          input logic [31:0] tgt, input logic [5:0] idx);
        upd_pc_e     = pc;
        upd_taken_e  = taken;
        upd_jump_e   = jump;
        upd_target_e = tgt;
        upd_idx_e    = idx;
        upd_valid_e  = 1'b1;
        @(posedge clk);
        #1;
        upd_valid_e  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        pc_f = 32'h100;
        upd_valid_e = 1'b0; upd_jump_e = 1'b0; upd_taken_e = 1'b0;
        upd_pc_e = 32'h0; upd_target_e = 32'h0; upd_idx_e = 6'd0;
        #2;  // before first clock edge
        checks++; if (hit_f !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", hit_f); end
        checks++; if (bp_f !== 1'b0) begin errors++; $display("FAIL reset_bp: got %b want 0", bp_f); end
        checks++; if (idx_f !== 6'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", idx_f); end
        rst = 1'b0;
        #1;
        checks++; if (hit_f !== 1'b0) begin errors++; $display("FAIL reset_release_hit: got %b want 0", hit_f); end
        pc_f = 32'h10C;
        #1;
        checks++; if (idx_f !== 6'd3) begin errors++; $display("FAIL reset_idx_10c: got %0d want 3", idx_f); end
    endtask

    task automatic test_train;
        pc_f = 32'h100;
        do_upd(32'h100, 1'b1, 1'b0, 32'h80, 6'd0);   // allocate ctr=2
        checks++; if (hit_f !== 1'b1) begin errors++; $display("FAIL train_hit: got %b want 1", hit_f); end
        checks++; if (bp_f !== 1'b1) begin errors++; $display("FAIL train_bp: got %b want 1", bp_f); end
        checks++; if (pred_target_f !== 32'h80) begin errors++; $display("FAIL train_target: got %h want 00000080", pred_target_f); end
    endtask

    task automatic test_saturation;
        logic exp_bp [7];
        logic tk     [7];
        // ctr: 2 ->1 ->0 ->0 ->1 ->2 ->3 ->3 via the list below, checking bp each step
        tk[0] = 1'b0; exp_bp[0] = 1'b0;   // 1
        tk[1] = 1'b0; exp_bp[1] = 1'b0;   // 0
        tk[2] = 1'b0; exp_bp[2] = 1'b0;   // 0 (held)
        tk[3] = 1'b1; exp_bp[3] = 1'b0;   // 1
        tk[4] = 1'b1; exp_bp[4] = 1'b1;   // 2
        tk[5] = 1'b1; exp_bp[5] = 1'b1;   // 3
        tk[6] = 1'b1; exp_bp[6] = 1'b1;   // 3 (held)
        pc_f = 32'h100;
        for (int i = 0; i < 7; i++) begin
            // not-taken updates carry a bogus target that must be ignored
            do_upd(32'h100, tk[i], 1'b0, (tk[i] ? 32'h84 : 32'hFFC), 6'd0);
            checks++; if (bp_f !== exp_bp[i]) begin errors++; $display("FAIL sat_bp step %0d: got %b want %b", i, bp_f, exp_bp[i]); end
            checks++; if (hit_f !== 1'b1) begin errors++; $display("FAIL sat_hit step %0d: got %b want 1", i, hit_f); end
            if (i == 2) begin
                checks++; if (pred_target_f !== 32'h80) begin errors++; $display("FAIL nt_target_kept: got %h want 00000080", pred_target_f); end
            end
        end
        checks++; if (pred_target_f !== 32'h84) begin errors++; $display("FAIL taken_target_refresh: got %h want 00000084", pred_target_f); end
        do_upd(32'h100, 1'b0, 1'b0, 32'h0, 6'd0);   // 3 -> 2, still taken
        checks++; if (bp_f !== 1'b1) begin errors++; $display("FAIL sat_max_dec: got %b want 1", bp_f); end
    endtask

    task automatic test_alias;
        pc_f = 32'h200;
        #1;
        checks++; if (hit_f !== 1'b0) begin errors++; $display("FAIL alias_hit: got %b want 0", hit_f); end
        checks++; if (bp_f !== 1'b0) begin errors++; $display("FAIL alias_bp: got %b want 0", bp_f); end
        do_upd(32'h200, 1'b0, 1'b0, 32'h44, 6'd0);  // not-taken miss: no write
        pc_f = 32'h100;
        #1;
        checks++; if (hit_f !== 1'b1) begin errors++; $display("FAIL nt_miss_nowrite: got %b want 1", hit_f); end
        do_upd(32'h200, 1'b1, 1'b0, 32'h40, 6'd0);  // replace, ctr=2
        checks++; if (hit_f !== 1'b0) begin errors++; $display("FAIL alias_old_miss: got %b want 0", hit_f); end
        pc_f = 32'h200;
        #1;
        checks++; if (hit_f !== 1'b1) begin errors++; $display("FAIL alias_new_hit: got %b want 1", hit_f); end
        checks++; if (pred_target_f !== 32'h40) begin errors++; $display("FAIL alias_new_target: got %h want 00000040", pred_target_f); end
    endtask

    task automatic test_same_cycle_and_jump;
        pc_f         = 32'h100;
        upd_pc_e     = 32'h100;
        upd_taken_e  = 1'b1;
        upd_jump_e   = 1'b0;
        upd_target_e = 32'h88;
        upd_idx_e    = 6'd0;
        upd_valid_e  = 1'b1;
        #1;
        checks++; if (hit_f !== 1'b0) begin errors++; $display("FAIL same_cycle_old: got %b want 0", hit_f); end
        @(posedge clk);
        #1;
        upd_valid_e = 1'b0;
        checks++; if (hit_f !== 1'b1) begin errors++; $display("FAIL same_cycle_new_hit: got %b want 1", hit_f); end
        checks++; if (pred_target_f !== 32'h88) begin errors++; $display("FAIL same_cycle_new_tgt: got %h want 00000088", pred_target_f); end
        pc_f = 32'h300;
        do_upd(32'h300, 1'b1, 1'b1, 32'h500, 6'd0);  // jump: ctr=3
        checks++; if (bp_f !== 1'b1) begin errors++; $display("FAIL jump_bp: got %b want 1", bp_f); end
        checks++; if (pred_target_f !== 32'h500) begin errors++; $display("FAIL jump_target: got %h want 00000500", pred_target_f); end
        do_upd(32'h300, 1'b0, 1'b0, 32'h0, 6'd0);    // 3 -> 2
        checks++; if (bp_f !== 1'b1) begin errors++; $display("FAIL jump_then_nt: got %b want 1", bp_f); end
    endtask

    task automatic test_back_to_back;
        do_upd(32'h104, 1'b1, 1'b0, 32'hA00, 6'd1);
        do_upd(32'h108, 1'b1, 1'b0, 32'hB00, 6'd2);
        // fields set but valid low: must not write
        upd_pc_e = 32'h10C; upd_taken_e = 1'b1; upd_target_e = 32'hC00; upd_idx_e = 6'd3;
        @(posedge clk);
        #1;
        pc_f = 32'h104;
        #1;
        checks++; if (pred_target_f !== 32'hA00 || hit_f !== 1'b1) begin errors++; $display("FAIL b2b_first: hit %b tgt %h want 1 00000a00", hit_f, pred_target_f); end
        pc_f = 32'h108;
        #1;
        checks++; if (pred_target_f !== 32'hB00 || hit_f !== 1'b1) begin errors++; $display("FAIL b2b_second: hit %b tgt %h want 1 00000b00", hit_f, pred_target_f); end
        pc_f = 32'h10C;
        #1;
        checks++; if (hit_f !== 1'b0) begin errors++; $display("FAIL idle_nowrite: got %b want 0", hit_f); end
    endtask

    task automatic test_mid_reset;
        pc_f = 32'h104;
        #1;
        rst = 1'b1;
        #1;
        checks++; if (hit_f !== 1'b0) begin errors++; $display("FAIL async_reset_hit: got %b want 0", hit_f); end
        checks++; if (idx_f !== 6'd1) begin errors++; $display("FAIL async_reset_idx: got %0d want 1", idx_f); end
        rst = 1'b0;
        pc_f = 32'h300;
        #1;
        checks++; if (hit_f !== 1'b0 || bp_f !== 1'b0) begin errors++; $display("FAIL reset_clears_300: hit %b bp %b want 0 0", hit_f, bp_f); end
        // a reset-valued counter is weakly not-taken: one not-taken hit would not matter,
        // one taken allocation gives weakly taken
        do_upd(32'h300, 1'b1, 1'b0, 32'h600, 6'd0);
        checks++; if (bp_f !== 1'b1) begin errors++; $display("FAIL realloc_bp: got %b want 1", bp_f); end
    endtask

`ifdef BPRED_GSHARE_EN
    task automatic test_gshare;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        pc_f = 32'h100;
        do_upd(32'h104, 1'b1, 1'b0, 32'h10, 6'd1);   // ghr 01
        do_upd(32'h108, 1'b0, 1'b0, 32'h10, 6'd2);   // ghr 10
        checks++; if (idx_f !== 6'd2) begin errors++; $display("FAIL gshare_idx: got %0d want 2", idx_f); end
        do_upd(32'h10C, 1'b1, 1'b1, 32'h10, 6'd3);   // jump: no shift
        checks++; if (idx_f !== 6'd2) begin errors++; $display("FAIL gshare_jump_noshift: got %0d want 2", idx_f); end
        rst = 1'b1;
        #1;
        checks++; if (idx_f !== 6'd0) begin errors++; $display("FAIL gshare_reset: got %0d want 0", idx_f); end
        rst = 1'b0;
        #1;
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
`ifdef BPRED_GSHARE_EN
        test_gshare();
`else
        test_train();
        test_saturation();
        test_alias();
        test_same_cycle_and_jump();
        test_back_to_back();
        test_mid_reset();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
